hazard_ctrl: RTL and testbench

Parametrised successor to the pipeline hazard unit of the five-stage core. It provides combinational operand forwarding for EX, with correct x0 and load-in-MEM suppression. It detects load-use hazards and holds a stall for a configurable memory latency through a small FSM. It also handles taken-branch flushes with priority over stalls, and counts stall cycles for performance monitoring.

---
 rtl/hazard_pkg.sv | 18 +
 rtl/hazard_fwd_path.sv | 44 ++++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: forwarding select codes and
// the load-use stall FSM state encoding.
package hazard_pkg;

  // Operand source select for an EX operand.
  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF  = 2'b00;  // regfile value latched into EX
  localparam fwd_sel_t FWD_WB  = 2'b01;  // final write-back data
  localparam fwd_sel_t FWD_MEM = 2'b10;  // ALU result sitting in MEM

  // Load-use stall sequencer states.
  typedef enum logic {
    IDLE      = 1'b0,
    LOAD_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_fwd_path.sv
// Forwarding compare and 3:1 operand mux for a single EX source operand.
// A MEM-stage producer wins over WB; loads in MEM cannot forward because
// their data is not available yet, and x0 never forwards.
module hazard_fwd_path
  import hazard_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [XLEN-1:0]   rf_data,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_is_load,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_data,
  output fwd_sel_t          sel,
  output logic [XLEN-1:0]   data
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_reg_write && !mem_is_load &&
                   (mem_rd != '0) && (mem_rd == ex_rs);
  assign wb_hit  = wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs);

  // Priority select of the newest producer, then the matching operand mux.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    sel  = FWD_RF;
    data = rf_data;
    if (mem_hit) begin
      sel  = FWD_MEM;
      data = mem_alu_result;
    end else if (wb_hit) begin
      sel  = FWD_WB;
      data = wb_data;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: EX operand forwarding, load-use stall sequencing
// for a configurable load latency, taken-branch flush (which overrides any
// stall) and a saturating stall-cycle performance counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic              mem_is_load,
  input  logic [XLEN-1:0]   mem_alu_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [XLEN-1:0]   ex_rs1_data,
  input  logic [XLEN-1:0]   ex_rs2_data,
  input  logic              branch_taken,
  output fwd_sel_t          fwd_a_sel,
  output fwd_sel_t          fwd_b_sel,
  output logic [XLEN-1:0]   fwd_a_data,
  output logic [XLEN-1:0]   fwd_b_data,
  output logic              stall_if,
  output logic              stall_id,
  output logic              bubble_ex,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [CNT_W-1:0]  stall_cycles
);

  // Wait counter only has to hold LOAD_LAT-1; keep at least one bit.
  localparam int CW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

  hz_state_t       state_q;
  logic [CW-1:0]   cnt_q;
  logic            load_use_hit;
  logic            stall;
  logic [CNT_W-1:0] stall_cycles_q;

  hazard_fwd_path #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_a (
    .ex_rs          (ex_rs1),
    .rf_data        (ex_rs1_data),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_is_load    (mem_is_load),
    .mem_alu_result (mem_alu_result),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .wb_data        (wb_data),
    .sel            (fwd_a_sel),
    .data           (fwd_a_data)
  );

  hazard_fwd_path #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_b (
    .ex_rs          (ex_rs2),
    .rf_data        (ex_rs2_data),
    .mem_rd         (mem_rd),
    .mem_reg_write  (mem_reg_write),
    .mem_is_load    (mem_is_load),
    .mem_alu_result (mem_alu_result),
    .wb_rd          (wb_rd),
    .wb_reg_write   (wb_reg_write),
    .wb_data        (wb_data),
    .sel            (fwd_b_sel),
    .data           (fwd_b_data)
  );

  assign load_use_hit = ex_is_load && (ex_rd != '0) &&
                        ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                         (id_use_rs2 && (id_rs2 == ex_rd)));

  // A stall is either a fresh hit in IDLE or an ongoing load wait; a taken
  // branch squashes it because the stalled instructions are being flushed.
  assign stall       = !branch_taken &&
                       ((state_q == LOAD_WAIT) || (state_q == IDLE && load_use_hit));
  assign stall_if    = stall;
  assign stall_id    = stall;
  assign bubble_ex   = stall;
  assign flush_if_id = branch_taken;
  assign flush_id_ex = branch_taken;

  // Load-use sequencer: first stall cycle happens in IDLE, the remaining
  // LOAD_LAT-1 cycles are counted down in LOAD_WAIT.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is assigned with <= so all flops update together.
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else if (branch_taken) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_use_hit && (LOAD_LAT > 1)) begin
            state_q <= LOAD_WAIT;
            cnt_q   <= CW'(LOAD_LAT - 1);
          end
        end
        LOAD_WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Saturating count of cycles in which the PC was held.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= '0;
    end else if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_q <= stall_cycles_q + CNT_W'(1);
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl. Three instances share one set of
// inputs: LOAD_LAT=1, LOAD_LAT=3 and LOAD_LAT=2 with a 3-bit stall counter.
// A reference model tracks remaining stall cycles and the stall count per
// instance; directed scenarios are followed by a randomized phase.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_use_rs1, id_use_rs2, ex_is_load;
  logic        mem_reg_write, mem_is_load, wb_reg_write, branch_taken;
  logic [31:0] mem_alu_result, wb_data, ex_rs1_data, ex_rs2_data;

  logic [1:0]  fas [3];
  logic [1:0]  fbs [3];
  logic [31:0] fad [3];
  logic [31:0] fbd [3];
  logic        s_if [3];
  logic        s_id [3];
  logic        bub [3];
  logic        f_ifid [3];
  logic        f_idex [3];
  logic [31:0] sc [3];
  logic [31:0] sc0, sc1;
  logic [2:0]  sc2;

  int checks = 0;
  int failures = 0;

  // Reference model state.
  int              lat [3]  = '{1, 3, 2};
  longint unsigned cmax [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd7};
  int              left [3];
  longint unsigned cnt [3];

  always #5 clk = ~clk;

  assign sc[0] = sc0;
  assign sc[1] = sc1;
  assign sc[2] = 32'(sc2);

  hazard_ctrl #(.LOAD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_alu_result(mem_alu_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .branch_taken(branch_taken), .fwd_a_sel(fas[0]), .fwd_b_sel(fbs[0]),
    .fwd_a_data(fad[0]), .fwd_b_data(fbd[0]), .stall_if(s_if[0]),
    .stall_id(s_id[0]), .bubble_ex(bub[0]), .flush_if_id(f_ifid[0]),
    .flush_id_ex(f_idex[0]), .stall_cycles(sc0)
  );

  hazard_ctrl #(.LOAD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_alu_result(mem_alu_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .branch_taken(branch_taken), .fwd_a_sel(fas[1]), .fwd_b_sel(fbs[1]),
    .fwd_a_data(fad[1]), .fwd_b_data(fbd[1]), .stall_if(s_if[1]),
    .stall_id(s_id[1]), .bubble_ex(bub[1]), .flush_if_id(f_ifid[1]),
    .flush_id_ex(f_idex[1]), .stall_cycles(sc1)
  );

  hazard_ctrl #(.LOAD_LAT(2), .CNT_W(3)) dut_sat (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .mem_rd(mem_rd),
    .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_alu_result(mem_alu_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_data(wb_data), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .branch_taken(branch_taken), .fwd_a_sel(fas[2]), .fwd_b_sel(fbs[2]),
    .fwd_a_data(fad[2]), .fwd_b_data(fbd[2]), .stall_if(s_if[2]),
    .stall_id(s_id[2]), .bubble_ex(bub[2]), .flush_if_id(f_ifid[2]),
    .flush_id_ex(f_idex[2]), .stall_cycles(sc2)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit hit_model();
    if (!ex_is_load || ex_rd == 5'd0) return 1'b0;
    return (id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd);
  endfunction

  // Expected operand source: newest non-load producer in MEM, then WB, then regfile.
  task automatic fwd_model(input logic [4:0] rs, input logic [31:0] rf,
                           output logic [1:0] sel, output logic [31:0] d);
    if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs && !mem_is_load) begin
      sel = 2'b10; d = mem_alu_result;
    end else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs) begin
      sel = 2'b01; d = wb_data;
    end else begin
      sel = 2'b00; d = rf;
    end
  endtask

  // One clock cycle: compare all outputs against the model mid-cycle, then
  // advance the model on the clock edge using the same inputs the DUTs saw.
  task automatic step(input bit do_check = 1'b1);
    logic [1:0]  es;
    logic [31:0] ed;
    bit          h, st;
    @(negedge clk);
    if (do_check) begin
      h = hit_model();
      for (int d = 0; d < 3; d++) begin
        st = !branch_taken && (left[d] > 0 || h);
        check($sformatf("d%0d.stall_if", d),    64'(s_if[d]),   64'(st));
        check($sformatf("d%0d.stall_id", d),    64'(s_id[d]),   64'(st));
        check($sformatf("d%0d.bubble_ex", d),   64'(bub[d]),    64'(st));
        check($sformatf("d%0d.flush_if_id", d), 64'(f_ifid[d]), 64'(branch_taken));
        check($sformatf("d%0d.flush_id_ex", d), 64'(f_idex[d]), 64'(branch_taken));
        check($sformatf("d%0d.stall_cycles", d), 64'(sc[d]), cnt[d]);
        fwd_model(ex_rs1, ex_rs1_data, es, ed);
        check($sformatf("d%0d.fwd_a_sel", d),  64'(fas[d]), 64'(es));
        check($sformatf("d%0d.fwd_a_data", d), 64'(fad[d]), 64'(ed));
        fwd_model(ex_rs2, ex_rs2_data, es, ed);
        check($sformatf("d%0d.fwd_b_sel", d),  64'(fbs[d]), 64'(es));
        check($sformatf("d%0d.fwd_b_data", d), 64'(fbd[d]), 64'(ed));
      end
    end
    @(posedge clk);
    h = hit_model();
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        left[d] = 0;
        cnt[d]  = 0;
      end else begin
        st = !branch_taken && (left[d] > 0 || h);
        if (st && cnt[d] < cmax[d]) cnt[d]++;
        if (branch_taken)     left[d] = 0;
        else if (left[d] > 0) left[d]--;
        else if (h)           left[d] = lat[d] - 1;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0;
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_is_load = 1'b0;
    mem_rd = '0; mem_reg_write = 1'b0; mem_is_load = 1'b0; mem_alu_result = '0;
    wb_rd = '0; wb_reg_write = 1'b0; wb_data = '0;
    ex_rs1_data = '0; ex_rs2_data = '0; branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic set_hit();
    ex_is_load = 1'b1; ex_rd = 5'd3; id_rs2 = 5'd3; id_use_rs2 = 1'b1;
  endtask

  task automatic clear_hit();
    ex_is_load = 1'b0; ex_rd = 5'd0; id_rs2 = 5'd0; id_use_rs2 = 1'b0;
  endtask

  initial begin
    foreach (left[d]) begin
      left[d] = 0;
      cnt[d]  = 0;
    end
    idle_inputs();
    reset = 1'b1;
    step(1'b0);
    step();
    reset = 1'b0;

    // Idle after reset: everything zero.
    #1;
    check("idle.stall_if", 64'(s_if[1]), 64'd0);
    check("idle.fwd_a_sel", 64'(fas[0]), 64'd0);
    check("idle.stall_cycles", 64'(sc[1]), 64'd0);
    step();

    // MEM beats WB for the same register; a load in MEM falls back to WB.
    mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1;
    ex_rs1 = 5'd5; mem_alu_result = 32'hAAAA; wb_data = 32'hBBBB;
    #1;
    check("fwd_mem.sel", 64'(fas[0]), 64'h2);
    check("fwd_mem.data", 64'(fad[0]), 64'hAAAA);
    step();
    mem_is_load = 1'b1;
    #1;
    check("fwd_wb.sel", 64'(fas[0]), 64'h1);
    check("fwd_wb.data", 64'(fad[0]), 64'hBBBB);
    step();

    // x0 never forwards and never stalls.
    idle_inputs();
    mem_rd = 5'd0; mem_reg_write = 1'b1; ex_rs2 = 5'd0; ex_rs2_data = 32'h1234;
    ex_is_load = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    check("x0.fwd_b_sel", 64'(fbs[0]), 64'h0);
    check("x0.fwd_b_data", 64'(fbd[0]), 64'h1234);
    check("x0.stall", 64'(s_if[1]), 64'd0);
    step();

    // Load-use hit for one cycle: LOAD_LAT=1 stalls once, LOAD_LAT=3 thrice.
    do_reset();
    set_hit();
    step();
    clear_hit();
    #1;
    check("lat1.stall_after", 64'(s_if[0]), 64'd0);
    check("lat1.count", 64'(sc[0]), 64'd1);
    check("lat3.stall_c2", 64'(s_if[1]), 64'd1);
    step();
    check("lat3.stall_c3", 64'(bub[1]), 64'd1);
    step();
    check("lat3.stall_c4", 64'(s_if[1]), 64'd0);
    check("lat3.count", 64'(sc[1]), 64'd3);
    step();

    // Branch in the 2nd stall cycle aborts the wait.
    do_reset();
    set_hit();
    step();
    clear_hit();
    branch_taken = 1'b1;
    #1;
    check("flush.stall_if", 64'(s_if[1]), 64'd0);
    check("flush.flush_if_id", 64'(f_ifid[1]), 64'd1);
    check("flush.flush_id_ex", 64'(f_idex[1]), 64'd1);
    step();
    branch_taken = 1'b0;
    #1;
    check("flush.after", 64'(s_if[1]), 64'd0);
    step();

    // Branch together with a fresh hit: flush only.
    set_hit();
    branch_taken = 1'b1;
    #1;
    check("flush_hit.stall", 64'(s_if[0]), 64'd0);
    check("flush_hit.flush", 64'(f_idex[0]), 64'd1);
    step();
    clear_hit();
    branch_taken = 1'b0;
    #1;
    check("flush_hit.after", 64'(s_if[1]), 64'd0);
    step();

    // Reset in the middle of a load wait.
    set_hit();
    step();
    clear_hit();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst_mid.stall", 64'(s_if[1]), 64'd0);
    check("rst_mid.count", 64'(sc[1]), 64'd0);
    step();

    // Nine stalled cycles saturate the 3-bit counter at 7.
    do_reset();
    set_hit();
    repeat (9) step();
    clear_hit();
    #1;
    check("sat.count3", 64'(sc[2]), 64'd7);
    check("sat.count32", 64'(sc[0]), 64'd9);
    step();

    // Randomized phase against the model.
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 39) == 0);
      id_rs1         = 5'($urandom_range(0, 3));
      id_rs2         = 5'($urandom_range(0, 3));
      id_use_rs1     = 1'($urandom);
      id_use_rs2     = 1'($urandom);
      ex_rs1         = 5'($urandom_range(0, 3));
      ex_rs2         = 5'($urandom_range(0, 3));
      ex_rd          = 5'($urandom_range(0, 3));
      ex_is_load     = 1'($urandom);
      mem_rd         = 5'($urandom_range(0, 3));
      mem_reg_write  = 1'($urandom);
      mem_is_load    = 1'($urandom);
      mem_alu_result = $urandom;
      wb_rd          = 5'($urandom_range(0, 3));
      wb_reg_write   = 1'($urandom);
      wb_data        = $urandom;
      ex_rs1_data    = $urandom;
      ex_rs2_data    = $urandom;
      branch_taken   = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
